ps2_rx_controller: RTL

- Sequences reception of PS/2 keyboard frames:
  - synchronizes the keyboard clock and data lines;
  - shifts in each 11-bit frame;
  - validates start, parity and stop bits;
  - folds E0 (extended) and F0 (break) prefix bytes into flags on the following scan code.
- Sits between the PS/2 pins and the scan-code decoder / SNES recoder.
- Replaces the free-running counter and zero-detect state machine with one controller that owns frame timing and error recovery.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_rx_controller_if.sv | 25 ++
 rtl/ps2_edge_sync.sv | 33 +++
 rtl/ps2_rx_controller.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      CHECK
   } ps2_state_e;

   localparam logic [7:0]  SC_EXT     = 8'hE0;
   localparam logic [7:0]  SC_BRK     = 8'hF0;
   localparam int unsigned FRAME_BITS = 11;

   // PS/2 uses odd parity: data byte plus parity bit must hold an odd number of ones.
   function automatic logic parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_controller_if.sv
// PS/2 pin inputs and decoded scan-code outputs of the receive controller.
interface ps2_rx_controller_if;

   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] code;
   logic       code_valid;
   logic       is_break;
   logic       is_extended;
   logic       frame_err;
   logic       busy;

   // Keyboard / consumer side: drives the pins, observes the decoded result.
   modport master (
      output ps2_clk, ps2_data,
      input  code, code_valid, is_break, is_extended, frame_err, busy
   );

   // Controller side.
   modport slave (
      input  ps2_clk, ps2_data,
      output code, code_valid, is_break, is_extended, frame_err, busy
   );

endinterface

// File: rtl/ps2_edge_sync.sv
// Synchronizes the asynchronous PS/2 lines and detects ps2_clk falling edges.
module ps2_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic data_s_o,
   output logic clk_fall_o
);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;

   // Synchronizer chains, preset to the idle-high bus level on reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      end
   end

   assign data_s_o   = data_sync_q[SYNC_STAGES-1];
   assign clk_fall_o = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard frame receiver: shifts in 11-bit frames, validates them and
// folds E0/F0 prefixes into flags on the following scan code.
module ps2_rx_controller
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 2080
) (
   input  logic               clk_i,
   input  logic               reset_i,
   ps2_rx_controller_if.slave bus
);

   localparam int unsigned        TmoW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TmoW-1:0]    TmoMax  = TmoW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]         LastBit = 4'(FRAME_BITS - 1);

   logic data_s;
   logic clk_fall;

   ps2_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .ps2_clk_i  (bus.ps2_clk),
      .ps2_data_i (bus.ps2_data),
      .data_s_o   (data_s),
      .clk_fall_o (clk_fall)
   );

   ps2_state_e      state_q, state_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   // [7:0] data byte, [8] parity, [9] stop; start bit is not kept.
   logic [9:0]      shift_q, shift_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            ext_pend_q, ext_pend_d;
   logic            brk_pend_q, brk_pend_d;
   logic [7:0]      code_q, code_d;
   logic            code_valid_q, code_valid_d;
   logic            is_break_q, is_break_d;
   logic            is_extended_q, is_extended_d;
   logic            frame_err_q, frame_err_d;

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         tmo_q         <= '0;
         ext_pend_q    <= 1'b0;
         brk_pend_q    <= 1'b0;
         code_q        <= '0;
         code_valid_q  <= 1'b0;
         is_break_q    <= 1'b0;
         is_extended_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         tmo_q         <= tmo_d;
         ext_pend_q    <= ext_pend_d;
         brk_pend_q    <= brk_pend_d;
         code_q        <= code_d;
         code_valid_q  <= code_valid_d;
         is_break_q    <= is_break_d;
         is_extended_q <= is_extended_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // Frame sequencing, validation and prefix folding.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      tmo_d         = tmo_q;
      ext_pend_d    = ext_pend_q;
      brk_pend_d    = brk_pend_q;
      code_d        = code_q;
      code_valid_d  = 1'b0;
      is_break_d    = is_break_q;
      is_extended_d = is_extended_q;
      frame_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A high sample on a fall is a glitch, not a start bit.
            if (clk_fall && !data_s) begin
               bit_cnt_d = 4'd1;
               tmo_d     = '0;
               state_d   = RECV;
            end
         end
         RECV: begin
            if (clk_fall) begin
               shift_d   = {data_s, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               tmo_d     = '0;
               if (bit_cnt_q == LastBit) begin
                  state_d = CHECK;
               end
            end else if (tmo_q == TmoMax) begin
               frame_err_d = 1'b1;
               ext_pend_d  = 1'b0;
               brk_pend_d  = 1'b0;
               bit_cnt_d   = '0;
               tmo_d       = '0;
               state_d     = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         CHECK: begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            if (!parity_ok(shift_q[7:0], shift_q[8]) || !shift_q[9]) begin
               frame_err_d = 1'b1;
               ext_pend_d  = 1'b0;
               brk_pend_d  = 1'b0;
            end else if (shift_q[7:0] == SC_EXT) begin
               ext_pend_d = 1'b1;
            end else if (shift_q[7:0] == SC_BRK) begin
               brk_pend_d = 1'b1;
            end else begin
               code_d        = shift_q[7:0];
               is_extended_d = ext_pend_q;
               is_break_d    = brk_pend_q;
               code_valid_d  = 1'b1;
               ext_pend_d    = 1'b0;
               brk_pend_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.code        = code_q;
   assign bus.code_valid  = code_valid_q;
   assign bus.is_break    = is_break_q;
   assign bus.is_extended = is_extended_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.busy        = (state_q != IDLE);

endmodule
